// File: rtl/an_corrector_n37_if.sv
// rtl/an_corrector_n37_if.sv - handshake bundle for the AN-code (A=37) single-bit corrector
//
// Purpose: carries the upstream Barrett-stage word and the downstream corrected result.
//   slave  : used by an_corrector_n37
//   master : used by whoever drives the words and consumes the results
// Signals:
//   in_valid/in_ready         upstream handshake
//   in_q, in_r, in_error      Barrett quotient, residue and nonzero-residue flag
//   in_codeword               received codeword
//   out_valid/out_ready       downstream handshake
//   out_data, out_codeword    corrected data and codeword
//   out_corrected             one bit was flipped
//   out_uncorrectable         no usable single-bit fix
//   out_bitpos                index of the flipped bit
//   out_corr_cnt, out_uncorr_cnt  16-bit saturating counters, present only with AN_CORR_STATS_EN
interface an_corrector_n37_if #(
  parameter int CW = 18,
  parameter int QW = 13,
  parameter int RW = 6,
  parameter int IW = 5
);
  logic          in_valid;
  logic          in_ready;
  logic [QW-1:0] in_q;
  logic [RW-1:0] in_r;
  logic          in_error;
  logic [CW-1:0] in_codeword;
  logic          out_valid;
  logic          out_ready;
  logic [QW-1:0] out_data;
  logic [CW-1:0] out_codeword;
  logic          out_corrected;
  logic          out_uncorrectable;
  logic [IW-1:0] out_bitpos;
`ifdef AN_CORR_STATS_EN
  logic [15:0]   out_corr_cnt;
  logic [15:0]   out_uncorr_cnt;
`endif

  modport slave (
    input  in_valid, in_q, in_r, in_error, in_codeword, out_ready,
    output in_ready, out_valid, out_data, out_codeword, out_corrected,
           out_uncorrectable, out_bitpos
`ifdef AN_CORR_STATS_EN
    , output out_corr_cnt, out_uncorr_cnt
`endif
  );

  modport master (
    output in_valid, in_q, in_r, in_error, in_codeword, out_ready,
    input  in_ready, out_valid, out_data, out_codeword, out_corrected,
           out_uncorrectable, out_bitpos
`ifdef AN_CORR_STATS_EN
    , input out_corr_cnt, out_uncorr_cnt
`endif
  );
endinterface

// File: rtl/an_corrector_n37.sv
// rtl/an_corrector_n37.sv - sequential single-bit corrector for AN-coded words, A = 37
//
// Purpose: takes the Barrett quotient/residue of a received codeword and, when the
// residue is nonzero, walks bit positions i = 0..CW-1 tracking 2^i mod A (pr) and
// floor(2^i / A) (pq) until the residue identifies a single flipped bit.
// Ports:
//   clk   clock
//   rst   synchronous active-high reset
//   bus   an_corrector_n37_if.slave (upstream word in, corrected result out)
// Optional feature: define AN_CORR_STATS_EN to add the 16-bit saturating
// corrected/uncorrectable result counters.
module an_corrector_n37 #(
  parameter int A  = 37,
  parameter int CW = 18,
  parameter int QW = 13,
  parameter int RW = 6,
  parameter int IW = 5
) (
  input logic              clk,
  input logic              rst,
  an_corrector_n37_if.slave bus
);

  localparam logic [RW:0]   A_EXT = (RW+1)'(A);
  localparam logic [IW-1:0] LAST  = IW'(CW - 1);

  typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;

  state_t        state_q;
  logic [QW-1:0] q_q;
  logic [RW-1:0] r_q;
  logic [CW-1:0] cw_q;
  logic [IW-1:0] i_q;
  logic [RW-1:0] pr_q;
  logic [QW-1:0] pq_q;
  logic          in_ready_q;
  logic          out_valid_q;
  logic [QW-1:0] out_data_q;
  logic [CW-1:0] out_cw_q;
  logic          out_corr_q;
  logic          out_unc_q;
  logic [IW-1:0] out_pos_q;

  logic          cw_bit;
  logic          pos_hit;
  logic          neg_hit;
  logic [RW:0]   neg_target;
  logic [QW:0]   fix_data;
  logic [CW-1:0] fix_cw;
  logic [RW:0]   t2;
  logic [RW:0]   t2_red;
  logic [RW-1:0] pr_d;
  logic [QW-1:0] pq_d;

  always_comb begin
    cw_bit     = cw_q[i_q];
    neg_target = A_EXT - {1'b0, pr_q};
    // Positive error added 2^i (r == 2^i mod A); negative error removed it (r == A - 2^i mod A).
    pos_hit    = cw_bit && (r_q == pr_q);
    neg_hit    = !cw_bit && ({1'b0, r_q} == neg_target);
    // Bit QW of the QW+1 result flags underflow (subtract) or overflow (add).
    if (pos_hit) begin
      fix_data = {1'b0, q_q} - {1'b0, pq_q};
    end else begin
      fix_data = {1'b0, q_q} + {1'b0, pq_q} + (QW+1)'(1);
    end
    fix_cw = cw_q ^ (CW'(1) << i_q);
    // Doubling step: 2^(i+1) = 2*pq*A + 2*pr, one conditional subtract keeps pr < A.
    t2     = {pr_q, 1'b0};
    t2_red = t2 - A_EXT;
    if (t2 >= A_EXT) begin
      pr_d = t2_red[RW-1:0];
      pq_d = {pq_q[QW-2:0], 1'b1};
    end else begin
      pr_d = t2[RW-1:0];
      pq_d = {pq_q[QW-2:0], 1'b0};
    end
  end

`ifdef AN_CORR_STATS_EN
  logic [15:0] corr_cnt_q;
  logic [15:0] uncorr_cnt_q;
  assign bus.out_corr_cnt   = corr_cnt_q;
  assign bus.out_uncorr_cnt = uncorr_cnt_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      q_q         <= '0;
      r_q         <= '0;
      cw_q        <= '0;
      i_q         <= '0;
      pr_q        <= '0;
      pq_q        <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_cw_q    <= '0;
      out_corr_q  <= 1'b0;
      out_unc_q   <= 1'b0;
      out_pos_q   <= '0;
`ifdef AN_CORR_STATS_EN
      corr_cnt_q   <= '0;
      uncorr_cnt_q <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            q_q        <= bus.in_q;
            r_q        <= bus.in_r;
            cw_q       <= bus.in_codeword;
            in_ready_q <= 1'b0;
            // The residue is authoritative; in_error is redundant with it.
            if (bus.in_r == '0) begin
              out_data_q  <= bus.in_q;
              out_cw_q    <= bus.in_codeword;
              out_corr_q  <= 1'b0;
              out_unc_q   <= 1'b0;
              out_pos_q   <= '0;
              out_valid_q <= 1'b1;
              state_q     <= DONE;
            end else begin
              i_q     <= '0;
              pr_q    <= RW'(1);
              pq_q    <= '0;
              state_q <= SEARCH;
            end
          end
        end
        SEARCH: begin
          if (pos_hit || neg_hit) begin
            if (fix_data[QW]) begin
              out_data_q <= q_q;
              out_cw_q   <= cw_q;
              out_corr_q <= 1'b0;
              out_unc_q  <= 1'b1;
              out_pos_q  <= '0;
            end else begin
              out_data_q <= fix_data[QW-1:0];
              out_cw_q   <= fix_cw;
              out_corr_q <= 1'b1;
              out_unc_q  <= 1'b0;
              out_pos_q  <= i_q;
            end
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else if (i_q == LAST) begin
            out_data_q  <= q_q;
            out_cw_q    <= cw_q;
            out_corr_q  <= 1'b0;
            out_unc_q   <= 1'b1;
            out_pos_q   <= '0;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            i_q  <= i_q + IW'(1);
            pr_q <= pr_d;
            pq_q <= pq_d;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
`ifdef AN_CORR_STATS_EN
            if (out_corr_q && corr_cnt_q != 16'hFFFF) corr_cnt_q <= corr_cnt_q + 16'd1;
            if (out_unc_q && uncorr_cnt_q != 16'hFFFF) uncorr_cnt_q <= uncorr_cnt_q + 16'd1;
`endif
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready          = in_ready_q;
  assign bus.out_valid         = out_valid_q;
  assign bus.out_data          = out_data_q;
  assign bus.out_codeword      = out_cw_q;
  assign bus.out_corrected     = out_corr_q;
  assign bus.out_uncorrectable = out_unc_q;
  assign bus.out_bitpos        = out_pos_q;

endmodule

// File: tb/tb_an_corrector_n37.sv
// tb/tb_an_corrector_n37.sv - directed scoreboard bench for an_corrector_n37
module tb_an_corrector_n37;
  localparam int CW = 18;
  localparam int QW = 13;
  localparam int RW = 6;
  localparam int IW = 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  an_corrector_n37_if #(.CW(CW), .QW(QW), .RW(RW), .IW(IW)) bus ();
  an_corrector_n37 dut (.clk(clk), .rst(rst), .bus(bus.slave));

  typedef struct {
    logic [QW-1:0] data;
    logic [CW-1:0] cw;
    logic          corr;
    logic          unc;
    logic [IW-1:0] pos;
    int            lat;
  } exp_t;

  exp_t sb[$];
  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic push(input int data, input int cw, input bit corr, input bit unc,
                      input int pos, input int lat);
    exp_t e;
    e.data = QW'(data);
    e.cw   = CW'(cw);
    e.corr = corr;
    e.unc  = unc;
    e.pos  = IW'(pos);
    e.lat  = lat;
    sb.push_back(e);
  endtask

  // Returns just after the accepting edge (E0 + 1).
  task automatic send(input int q, input int r, input bit err, input int cw);
    int n = 0;
    while (bus.in_ready !== 1'b1 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    chk("in_ready_before_send", 32'(bus.in_ready), 32'd1);
    bus.in_q        = QW'(q);
    bus.in_r        = RW'(r);
    bus.in_error    = err;
    bus.in_codeword = CW'(cw);
    bus.in_valid    = 1'b1;
    @(posedge clk); #1;
    bus.in_valid    = 1'b0;
  endtask

  task automatic collect(input string tag, input int hold);
    int lat = 1;
    exp_t e;
    while (bus.out_valid !== 1'b1 && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    if (sb.size() == 0) begin
      chk({tag, ".sb_empty"}, 32'(sb.size()), 32'd1);
      return;
    end
    e = sb.pop_front();
    chk({tag, ".out_valid"}, 32'(bus.out_valid), 32'd1);
    chk({tag, ".latency"}, 32'(lat), 32'(e.lat));
    chk({tag, ".data"}, 32'(bus.out_data), 32'(e.data));
    chk({tag, ".codeword"}, 32'(bus.out_codeword), 32'(e.cw));
    chk({tag, ".corrected"}, 32'(bus.out_corrected), 32'(e.corr));
    chk({tag, ".uncorrectable"}, 32'(bus.out_uncorrectable), 32'(e.unc));
    chk({tag, ".bitpos"}, 32'(bus.out_bitpos), 32'(e.pos));
    chk({tag, ".in_ready_busy"}, 32'(bus.in_ready), 32'd0);
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      chk({tag, ".hold_valid"}, 32'(bus.out_valid), 32'd1);
      chk({tag, ".hold_ready"}, 32'(bus.in_ready), 32'd0);
      chk({tag, ".hold_data"}, 32'(bus.out_data), 32'(e.data));
      chk({tag, ".hold_cw"}, 32'(bus.out_codeword), 32'(e.cw));
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk({tag, ".valid_after_hs"}, 32'(bus.out_valid), 32'd0);
    chk({tag, ".ready_after_hs"}, 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int seen_valid;
    rst             = 1'b1;
    bus.in_valid    = 1'b0;
    bus.in_q        = '0;
    bus.in_r        = '0;
    bus.in_error    = 1'b0;
    bus.in_codeword = '0;
    bus.out_ready   = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    chk("reset.out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset.in_ready", 32'(bus.in_ready), 32'd1);
    chk("reset.out_data", 32'(bus.out_data), 32'd0);
    chk("reset.out_codeword", 32'(bus.out_codeword), 32'd0);
    chk("reset.out_corrected", 32'(bus.out_corrected), 32'd0);
    chk("reset.out_uncorrectable", 32'(bus.out_uncorrectable), 32'd0);
    chk("reset.out_bitpos", 32'(bus.out_bitpos), 32'd0);
`ifdef AN_CORR_STATS_EN
    chk("reset.corr_cnt", 32'(bus.out_corr_cnt), 32'd0);
    chk("reset.uncorr_cnt", 32'(bus.out_uncorr_cnt), 32'd0);
`endif

    // Clean word, with in_error contradicting a zero residue (residue wins).
    push(100, 3700, 0, 0, 0, 1);
    send(100, 0, 1, 3700);
    collect("clean", 0);

    push(100, 3700, 1, 0, 0, 2);
    send(100, 1, 1, 3701);
    collect("bit0_set", 0);

    // Bit 7 set, also exercises 10 cycles of backpressure.
    push(100, 3700, 1, 0, 7, 9);
    send(103, 17, 1, 3828);
    collect("bit7_set", 10);

    push(100, 3700, 1, 0, 2, 4);
    send(99, 33, 1, 3696);
    collect("bit2_clr", 0);

`ifdef AN_CORR_STATS_EN
    chk("stats.corr_cnt", 32'(bus.out_corr_cnt), 32'd3);
    chk("stats.uncorr_cnt", 32'(bus.out_uncorr_cnt), 32'd0);
`endif

    // Negative-error fix at i=0 would produce q+1 = 8192: overflow, raw output.
    push(8191, 0, 0, 1, 0, 2);
    send(8191, 36, 1, 0);
    collect("overflow", 0);

    // Positive-error fix at i=6 (pq=1) with q=0: underflow, raw output.
    push(0, 64, 0, 1, 0, 8);
    send(0, 27, 1, 64);
    collect("underflow", 0);

`ifdef AN_CORR_STATS_EN
    chk("stats.corr_cnt2", 32'(bus.out_corr_cnt), 32'd3);
    chk("stats.uncorr_cnt2", 32'(bus.out_uncorr_cnt), 32'd2);
`endif

    // Reset while searching at i = 3: the word must be dropped.
    send(103, 17, 1, 3828);
    seen_valid = 0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      if (bus.out_valid === 1'b1) seen_valid++;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort.in_ready", 32'(bus.in_ready), 32'd1);
    chk("abort.out_corrected", 32'(bus.out_corrected), 32'd0);
    chk("abort.out_uncorrectable", 32'(bus.out_uncorrectable), 32'd0);
    chk("abort.out_data", 32'(bus.out_data), 32'd0);
    for (int k = 0; k < 15; k++) begin
      @(posedge clk); #1;
      if (bus.out_valid === 1'b1) seen_valid++;
    end
    chk("abort.out_valid_never", 32'(seen_valid), 32'd0);
    chk("abort.in_ready_idle", 32'(bus.in_ready), 32'd1);
`ifdef AN_CORR_STATS_EN
    chk("abort.corr_cnt", 32'(bus.out_corr_cnt), 32'd0);
`endif

    // Block must still work after the aborting reset.
    push(100, 3700, 1, 0, 2, 4);
    send(99, 33, 0, 3696);
    collect("post_reset", 0);

    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
